coef_loader: RTL
================

COEF_LOADER -- requirements
Module: coef_loader

Interface
REQ-001 The parameter WIDTH, default 32, SHALL set the coefficient width in bits and SHALL be a multiple of 8, at least 8.
REQ-002 The parameter NUM_COEF, default 2, SHALL set the number of coefficients per frame (range 1-8).
REQ-003 The parameter HDR, default 8'hA5, SHALL set the frame header byte.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Port rst  input  1  asynchronous active-high reset.
REQ-007 Port ena  input  1  when low, the FSM SHALL hold state and SHALL ignore in_valid.
REQ-008 Port in_byte  input  8  serial byte from the pins.
REQ-009 Port in_valid  input  1  in_byte is sampled in a cycle where in_valid=1 and ena=1.
REQ-010 Port core_busy  input  1  the downstream core is computing.
REQ-011 Port coef_out  output  NUM_COEF*WIDTH  committed coefficients; coefficient k occupies bits [k*WIDTH +: WIDTH].
REQ-012 Port start_calc  output  1  1-cycle start pulse to the core.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.
REQ-014 Port err  output  1  sticky flag for checksum or framing error.

Function
REQ-015 The frame format SHALL be: HDR, then NUM_COEF*WIDTH/8 payload bytes (coefficient 0 first, each coefficient LSB byte first), then one checksum byte equal to the XOR of all payload bytes.
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, CHECK, WAIT_CORE and FIRE.
REQ-017 IDLE: a sampled byte equal to HDR SHALL move the FSM to LOAD, clear the byte counter and running XOR, and clear err; any other sampled byte SHALL be discarded with no state change.
REQ-018 LOAD: each sampled byte SHALL be written into a shadow register at byte index cnt and XORed into the running checksum, and cnt SHALL increment.
REQ-019 LOAD: the FSM SHALL go to CHECK after the last payload byte (cnt = NUM_COEF*WIDTH/8 - 1).
REQ-020 CHECK: on a sampled byte equal to the running XOR, the FSM SHALL go to WAIT_CORE.
REQ-021 CHECK: on a mismatching sampled byte, the FSM SHALL set err=1, go to IDLE, and leave coef_out unchanged.
REQ-022 WAIT_CORE: the FSM SHALL remain while core_busy=1; when core_busy=0 it SHALL copy the shadow register to coef_out and go to FIRE in the same edge.
REQ-023 FIRE: start_calc SHALL be 1 for exactly this one cycle, then the FSM SHALL return to IDLE.
REQ-024 Bytes arriving in WAIT_CORE or FIRE SHALL be dropped; no buffering SHALL be provided.
REQ-025 Latency from the edge sampling the checksum byte to start_calc=1 SHALL be 2 cycles when core_busy=0, i.e. the pulse is seen at edge+2.
REQ-026 coef_out SHALL change only on the WAIT_CORE-to-FIRE transition and SHALL never expose a partial frame.
REQ-027 ena=0 mid-frame SHALL freeze cnt, the XOR and the state.
REQ-028 ena=0 SHALL NOT suppress a start_calc pulse already in FIRE.
REQ-029 A payload byte equal to HDR SHALL be treated as data, not as a resync.
REQ-030 The counter width SHALL be clog2(NUM_COEF*WIDTH/8) bits and SHALL NOT wrap inside a frame.

Reset
REQ-031 On rst=1, independent of clk, the block SHALL set state=IDLE, cnt=0, XOR=0, shadow=0, coef_out=0, start_calc=0, busy=0 and err=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame.
REQ-033 The first frame after reset release SHALL load normally.

Verification (defaults, WIDTH=32, NUM_COEF=2)
REQ-034 Scenario nominal: send A5, 01 02 03 04 05 06 07 08, checksum 08 with core_busy=0 -> coef_out=64'h0807060504030201, one start_calc pulse 2 cycles after the checksum edge, err=0.
REQ-035 Scenario bad checksum: the same frame with checksum 09 -> err=1, no start_calc, coef_out keeps its previous value, busy=0.
REQ-036 Scenario core busy: a valid frame while core_busy=1 for 10 cycles -> busy=1 and coef_out unchanged throughout, then start_calc exactly 1 cycle after core_busy falls.
REQ-037 Scenario gaps and ena: in_valid toggling and ena=0 for 5 cycles mid-payload -> the result is identical to the nominal scenario.
REQ-038 Scenario reset mid-frame: rst pulse after payload byte 4, then a full frame -> coef_out equals the second frame's payload and only one start_calc pulse occurs.
REQ-039 Scenario parameter sweep (WIDTH=16, NUM_COEF=3, 6 payload bytes): garbage bytes before A5 are ignored and a payload byte A5 is loaded as data -> correct packing into coef_out.

Source files
------------

// File: rtl/coef_loader.sv
// coef_loader: receives a framed byte stream (HDR, payload, XOR checksum),
// assembles NUM_COEF coefficients of WIDTH bits in a shadow register, and on a
// good checksum commits them to coef_out and pulses start_calc once the
// downstream core is idle.
// Ports: clk, rst (async, active high), ena (global hold), in_byte/in_valid
// (byte stream), core_busy (core computing); coef_out (committed
// coefficients, coef k at [k*WIDTH +: WIDTH]), start_calc (1-cycle start),
// busy (not IDLE), err (sticky checksum/framing error, cleared by next HDR).
module coef_loader #(
   parameter int          WIDTH    = 32,
   parameter int          NUM_COEF = 2,
   parameter logic [7:0]  HDR      = 8'hA5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic [7:0]                in_byte,
   input  logic                      in_valid,
   input  logic                      core_busy,
   output logic [NUM_COEF*WIDTH-1:0] coef_out,
   output logic                      start_calc,
   output logic                      busy,
   output logic                      err
);

   localparam int TOTW   = NUM_COEF * WIDTH;
   localparam int NBYTES = TOTW / 8;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      WAIT_CORE,
      FIRE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      xor_q, xor_d;
   logic [TOTW-1:0] shadow_q, shadow_d;
   logic [TOTW-1:0] coef_q, coef_d;
   logic            err_q, err_d;
   logic            take;

   assign take = in_valid & ena;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      xor_d    = xor_q;
      shadow_d = shadow_q;
      coef_d   = coef_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (take && in_byte == HDR) begin
               state_d = LOAD;
               cnt_d   = '0;
               xor_d   = '0;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            if (take) begin
               for (int i = 0; i < NBYTES; i++) begin
                  if (cnt_q == CW'(i)) begin
                     shadow_d[i*8 +: 8] = in_byte;
                  end
               end
               xor_d = xor_q ^ in_byte;
               // counter parks on the last index rather than wrapping
               if (cnt_q == LAST) begin
                  state_d = CHECK;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         CHECK: begin
            if (take) begin
               if (in_byte == xor_q) begin
                  state_d = WAIT_CORE;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_CORE: begin
            // commit is the only point coef_out may change
            if (ena && !core_busy) begin
               coef_d  = shadow_q;
               state_d = FIRE;
            end
         end
         FIRE: begin
            // leaves unconditionally so ena cannot stretch or kill the pulse
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         xor_q    <= '0;
         shadow_q <= '0;
         coef_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         xor_q    <= xor_d;
         shadow_q <= shadow_d;
         coef_q   <= coef_d;
         err_q    <= err_d;
      end
   end

   assign coef_out   = coef_q;
   assign start_calc = (state_q == FIRE);
   assign busy       = (state_q != IDLE);
   assign err        = err_q;

endmodule
